// File: rtl/shift_engine_if.sv
// shift_engine_if: request/result bundle between the ALU decoder and
// shift_engine.
//   master : decoder side, drives start/a/b/sel_b/mode/amount and
//            observes busy/done/shift_out/shift_flag/carry_out.
//   slave  : shift_engine side.
// With SHIFT_ENGINE_ABORT_EN defined the bundle also carries
// abort (master->slave) and aborted (slave->master).
interface shift_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 5
);
  logic                  start;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  sel_b;
  logic [2:0]            mode;
  logic [AMT_WIDTH-1:0]  amount;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] shift_out;
  logic                  shift_flag;
  logic                  carry_out;
`ifdef SHIFT_ENGINE_ABORT_EN
  logic                  abort;
  logic                  aborted;

  modport master (output start, a, b, sel_b, mode, amount, abort,
                  input  busy, done, shift_out, shift_flag, carry_out, aborted);
  modport slave  (input  start, a, b, sel_b, mode, amount, abort,
                  output busy, done, shift_out, shift_flag, carry_out, aborted);
`else
  modport master (output start, a, b, sel_b, mode, amount,
                  input  busy, done, shift_out, shift_flag, carry_out);
  modport slave  (input  start, a, b, sel_b, mode, amount,
                  output busy, done, shift_out, shift_flag, carry_out);
`endif
endinterface

// File: rtl/shift_engine.sv
// shift_engine: iterative multi-mode shifter (LSR/LSL/ASR/ROR/ROL/pass).
// Moves up to STEP bit positions per clock, start/busy/done handshake,
// result and flag held until the next completion.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - shift_engine_if.slave (start, a, b, sel_b, mode, amount in;
//          busy, done, shift_out, shift_flag, carry_out out)
// Optional feature macro: SHIFT_ENGINE_ABORT_EN adds abort/aborted, which
// cancels an operation in SHIFT with no done and no result update.
module shift_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 5,
  parameter int STEP       = 1
) (
  input  logic           clk,
  input  logic           rst,
  shift_engine_if.slave  bus
);
  localparam logic [2:0] M_LSR = 3'd0, M_LSL = 3'd1, M_ASR = 3'd2,
                         M_ROR = 3'd3, M_ROL = 3'd4;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [2:0]            mode_q, mode_d;
  logic [AMT_WIDTH-1:0]  rem_q, rem_d;
  logic                  carry_q, carry_d;
  logic                  cout_q, cout_d;
  logic                  flag_q, flag_d;
  logic                  aborted_q, aborted_d;

  logic [DATA_WIDTH-1:0] step_w;
  logic                  step_c;
  logic [31:0]           k;
  logic [DATA_WIDTH-1:0] op;

  assign op = bus.sel_b ? bus.b : bus.a;

  // One clock of shifting: k = min(STEP, remaining) single-bit moves,
  // unrolled so any amount >= DATA_WIDTH falls out naturally.
  always_comb begin
    k      = (32'(rem_q) > 32'(STEP)) ? 32'(STEP) : 32'(rem_q);
    step_w = work_q;
    step_c = carry_q;
    for (int i = 0; i < STEP; i++) begin
      if (32'(i) < k) begin
        case (mode_q)
          M_LSR: begin step_c = step_w[0];            step_w = {1'b0, step_w[DATA_WIDTH-1:1]}; end
          M_LSL: begin step_c = step_w[DATA_WIDTH-1]; step_w = {step_w[DATA_WIDTH-2:0], 1'b0}; end
          M_ASR: begin step_c = step_w[0];            step_w = {step_w[DATA_WIDTH-1], step_w[DATA_WIDTH-1:1]}; end
          M_ROR: begin step_c = step_w[0];            step_w = {step_w[0], step_w[DATA_WIDTH-1:1]}; end
          M_ROL: begin step_c = step_w[DATA_WIDTH-1]; step_w = {step_w[DATA_WIDTH-2:0], step_w[DATA_WIDTH-1]}; end
          default: ;
        endcase
      end
    end
  end

  // Result registers load on the transition into FIN, so shift_out and
  // carry_out are already valid in the cycle done is high.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    res_d     = res_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    flag_d    = flag_q;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        work_d  = op;
        mode_d  = bus.mode;
        rem_d   = bus.amount;
        carry_d = 1'b0;
        flag_d  = 1'b0;
        if (bus.amount == '0 || bus.mode > M_ROL) begin
          state_d = FIN;
          res_d   = op;
          cout_d  = 1'b0;
          flag_d  = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = step_w;
        carry_d = step_c;
        rem_d   = rem_q - AMT_WIDTH'(k);
        if (32'(rem_q) <= 32'(STEP)) begin
          state_d = FIN;
          res_d   = step_w;
          cout_d  = step_c;
          flag_d  = 1'b1;
        end
`ifdef SHIFT_ENGINE_ABORT_EN
        // Abort wins over a completion in the same cycle.
        if (bus.abort) begin
          state_d   = IDLE;
          res_d     = res_q;
          cout_d    = cout_q;
          flag_d    = flag_q;
          aborted_d = 1'b1;
        end
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      res_q     <= '0;
      mode_q    <= '0;
      rem_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      flag_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      res_q     <= res_d;
      mode_q    <= mode_d;
      rem_q     <= rem_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      flag_q    <= flag_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == FIN);
  assign bus.shift_out  = res_q;
  assign bus.carry_out  = cout_q;
  assign bus.shift_flag = flag_q;
`ifdef SHIFT_ENGINE_ABORT_EN
  assign bus.aborted    = aborted_q;
`else
  // aborted_q stays 0 without the abort feature; keep it observed.
  logic unused_ok;
  assign unused_ok = aborted_q;
`endif
endmodule

// File: tb/tb_shift_engine.sv
module tb_shift_engine;
  logic clk, rst;
  logic start, sel_b, abort;
  logic [15:0] a, b;
  logic [2:0] mode;
  logic [4:0] amount;
  int ncmp = 0, nerr = 0;

  shift_engine_if #(.DATA_WIDTH(16), .AMT_WIDTH(5)) if1 ();
  shift_engine_if #(.DATA_WIDTH(16), .AMT_WIDTH(5)) if4 ();

  assign if1.start = start;  assign if4.start = start;
  assign if1.a = a;          assign if4.a = a;
  assign if1.b = b;          assign if4.b = b;
  assign if1.sel_b = sel_b;  assign if4.sel_b = sel_b;
  assign if1.mode = mode;    assign if4.mode = mode;
  assign if1.amount = amount; assign if4.amount = amount;
`ifdef SHIFT_ENGINE_ABORT_EN
  assign if1.abort = abort;  assign if4.abort = abort;
`endif

  shift_engine #(.DATA_WIDTH(16), .AMT_WIDTH(5), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  shift_engine #(.DATA_WIDTH(16), .AMT_WIDTH(5), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, hold start for
  // 'hold' edges, then check latency, result, carry, flag and the IDLE
  // return on the following edge.
  task automatic op(input bit use4, input logic sb, input logic [15:0] av, input logic [15:0] bv,
                    input logic [2:0] md, input logic [4:0] amt, input int hold,
                    input int exp_edges, input logic [15:0] exp_o, input logic exp_c,
                    input string tag);
    int edges;
    bit got;
    logic dn, bz, fl, co;
    logic [15:0] so;
    @(negedge clk);
    sel_b = sb; a = av; b = bv; mode = md; amount = amt; start = 1'b1;
    edges = 0; got = 0;
    while (!got && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin a = ~av; b = ~bv; mode = 3'd1; amount = 5'd0; end
      if (edges >= hold) start = 1'b0;
      dn = use4 ? if4.done : if1.done;
      fl = use4 ? if4.shift_flag : if1.shift_flag;
      if (edges == 1 && exp_edges > 1) chk({tag, " flag cleared"}, 32'(fl), 32'd0);
      if (dn) got = 1;
    end
    so = use4 ? if4.shift_out : if1.shift_out;
    co = use4 ? if4.carry_out : if1.carry_out;
    fl = use4 ? if4.shift_flag : if1.shift_flag;
    chk({tag, " edges"}, 32'(edges), 32'(exp_edges));
    chk({tag, " out"}, 32'(so), 32'(exp_o));
    chk({tag, " carry"}, 32'(co), 32'(exp_c));
    chk({tag, " flag"}, 32'(fl), 32'd1);
    @(posedge clk); #1;
    bz = use4 ? if4.busy : if1.busy;
    fl = use4 ? if4.shift_flag : if1.shift_flag;
    so = use4 ? if4.shift_out : if1.shift_out;
    chk({tag, " idle busy"}, 32'(bz), 32'd0);
    chk({tag, " held flag"}, 32'(fl), 32'd1);
    chk({tag, " held out"}, 32'(so), 32'(exp_o));
  endtask

  initial begin
    bit saw_done;
    rst = 1'b0; start = 1'b0; sel_b = 1'b0; abort = 1'b0;
    a = '0; b = '0; mode = '0; amount = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(if1.busy), 32'd0);
    chk("reset done", 32'(if1.done), 32'd0);
    chk("reset out", 32'(if1.shift_out), 32'd0);
    chk("reset flag", 32'(if1.shift_flag), 32'd0);
    chk("reset carry", 32'(if1.carry_out), 32'd0);
    @(negedge clk); rst = 1'b1;

    //      4  sb   a        b        mode  amt  hold edges out      c
    op(0, 0, 16'h8001, 16'h0000, 3'd0, 5'd1,  1, 2,  16'h4000, 1'b1, "lsr1");
    op(0, 0, 16'h8000, 16'h0000, 3'd2, 5'd4,  1, 5,  16'hF800, 1'b0, "asr4");
    op(0, 1, 16'hFFFF, 16'h8001, 3'd4, 5'd17, 1, 18, 16'h0003, 1'b1, "rol17b");
    op(0, 0, 16'h00FF, 16'h0000, 3'd1, 5'd20, 1, 21, 16'h0000, 1'b0, "lsl20");
    op(0, 0, 16'h1234, 16'h0000, 3'd1, 5'd0,  1, 1,  16'h1234, 1'b0, "lsl0");
    op(0, 0, 16'hABCD, 16'h0000, 3'd5, 5'd7,  1, 1,  16'hABCD, 1'b0, "pass");
    op(0, 0, 16'h8000, 16'h0000, 3'd0, 5'd16, 1, 17, 16'h0000, 1'b1, "lsr16");
    op(0, 0, 16'h0001, 16'h0000, 3'd3, 5'd1,  1, 2,  16'h8000, 1'b1, "ror1");
    op(0, 0, 16'h8000, 16'h0000, 3'd2, 5'd31, 1, 32, 16'hFFFF, 1'b1, "asr31");
    // start held high while busy: later samples must be ignored
    op(0, 0, 16'h00F0, 16'h0000, 3'd0, 5'd3,  3, 4,  16'h001E, 1'b0, "busystart");

`ifdef SHIFT_ENGINE_ABORT_EN
    op(0, 0, 16'h8001, 16'h0000, 3'd0, 5'd1,  1, 2,  16'h4000, 1'b1, "preabort");
    @(negedge clk);
    a = 16'hFFFF; mode = 3'd0; amount = 5'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    chk("abort pulse", 32'(if1.aborted), 32'd1);
    chk("abort busy", 32'(if1.busy), 32'd0);
    chk("abort done", 32'(if1.done), 32'd0);
    abort = 1'b0;
    @(posedge clk); #1;
    chk("abort pulse end", 32'(if1.aborted), 32'd0);
    chk("abort out kept", 32'(if1.shift_out), 32'h4000);
    chk("abort carry kept", 32'(if1.carry_out), 32'd1);
    chk("abort flag", 32'(if1.shift_flag), 32'd0);
    saw_done = 0;
    repeat (12) begin @(posedge clk); #1; if (if1.done) saw_done = 1; end
    chk("abort no done", 32'(saw_done), 32'd0);
`endif

    // reset in the middle of SHIFT
    @(negedge clk);
    sel_b = 1'b0; a = 16'h8001; mode = 3'd0; amount = 5'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst busy", 32'(if1.busy), 32'd0);
    chk("midrst done", 32'(if1.done), 32'd0);
    chk("midrst out", 32'(if1.shift_out), 32'd0);
    chk("midrst flag", 32'(if1.shift_flag), 32'd0);
    chk("midrst carry", 32'(if1.carry_out), 32'd0);
    @(negedge clk); rst = 1'b1;
    saw_done = 0;
    repeat (12) begin @(posedge clk); #1; if (if1.done) saw_done = 1; end
    chk("midrst no done", 32'(saw_done), 32'd0);
    op(0, 0, 16'h8001, 16'h0000, 3'd0, 5'd1,  1, 2,  16'h4000, 1'b1, "postrst");

    // STEP=4 instance
    op(1, 0, 16'h0001, 16'h0000, 3'd1, 5'd6,  1, 3,  16'h0040, 1'b0, "s4lsl6");
    op(1, 0, 16'h00F1, 16'h0000, 3'd3, 5'd5,  1, 3,  16'h8807, 1'b1, "s4ror5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
